// File: rtl/test_top_sys_pkg.sv
// Shared types and constants for the test_top_sys smoke design.
package test_top_sys_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } gen_state_e;

    localparam int unsigned     CNT_W       = 16;
    localparam logic [CNT_W-1:0] ERR_CNT_MAX = 16'hFFFF;

    function automatic int unsigned total_beats(input int unsigned pkt_num,
                                                input int unsigned pkt_len);
        return pkt_num * pkt_len;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Synchronous registered-output FIFO for {tlast,tdata} beats; pointers carry one wrap bit.
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready_c,
    output logic             rd_valid_c,
    output logic [WIDTH-1:0] rd_data_c,
    input  logic             rd_ready
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_valid_c = !empty;
    assign rd_en      = rd_valid_c && rd_ready;
    // A full FIFO still accepts a write in the same cycle a word leaves.
    assign wr_ready_c = !full || rd_en;
    assign wr_en      = wr_valid && wr_ready_c;
    assign rd_data_c  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/test_top_sys.sv
// Generator -> FIFO -> checker smoke top. Define TEST_TOP_BP_EN to throttle the checker 3-of-4 cycles.
module test_top_sys
    import test_top_sys_pkg::*;
#(
    parameter int unsigned DSIZE      = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PKT_LEN    = 16,
    parameter int unsigned PKT_NUM    = 4
) (
    input  logic             global_sys_clk,
    input  logic             global_sys_rst_n,
    input  logic             start,
    input  logic             err_inject,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] beat_cnt
);
    localparam int unsigned TOTAL = total_beats(PKT_NUM, PKT_LEN);
    localparam int unsigned KW    = $clog2(PKT_LEN);
    localparam int unsigned PW    = $clog2(PKT_NUM + 1);

    logic [1:0] rst_sync;
    logic       rst_n;
    logic       start_q;
    logic       start_qq;
    logic       run_start;

    gen_state_e       gen_state;
    logic [KW-1:0]    gen_k;
    logic [PW-1:0]    gen_p;
    logic [DSIZE-1:0] gen_d;
    logic             gen_valid;
    logic             gen_ready;
    logic             gen_last;
    logic             gen_fire;
    logic [DSIZE-1:0] gen_data;

    logic             chk_valid;
    logic             chk_ready;
    logic             chk_last;
    logic [DSIZE-1:0] chk_data;
    logic             chk_fire;
    logic             beat_err;
    logic [DSIZE-1:0] exp_d;
    logic [KW-1:0]    exp_k;
    logic             all_seen;

    // Asynchronous assert, synchronous release.
    always_ff @(posedge global_sys_clk or negedge global_sys_rst_n) begin
        if (!global_sys_rst_n) rst_sync <= '0;
        else                   rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge global_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q  <= 1'b0;
            start_qq <= 1'b0;
        end else begin
            start_q  <= start;
            start_qq <= start_q;
        end
    end
    assign run_start = start_q && !start_qq && !busy;

    assign gen_valid = (gen_state == SEND);
    assign gen_last  = (gen_k == KW'(PKT_LEN - 1));
    assign gen_data  = gen_d ^ DSIZE'(err_inject);
    assign gen_fire  = gen_valid && gen_ready;

    // Generator: counter pattern, advances only on accepted beats.
    always_ff @(posedge global_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_state <= IDLE;
            gen_k     <= '0;
            gen_p     <= '0;
            gen_d     <= '0;
        end else if (run_start) begin
            gen_state <= SEND;
            gen_k     <= '0;
            gen_p     <= '0;
            gen_d     <= '0;
        end else begin
            case (gen_state)
                SEND: begin
                    if (gen_fire) begin
                        gen_d <= gen_d + DSIZE'(1);
                        if (gen_last) begin
                            gen_k <= '0;
                            gen_p <= gen_p + PW'(1);
                            if (gen_p == PW'(PKT_NUM - 1)) gen_state <= FINISH;
                        end else begin
                            gen_k <= gen_k + KW'(1);
                        end
                    end
                end
                FINISH:  if (done) gen_state <= IDLE;
                default: ;
            endcase
        end
    end

    axis_sync_fifo #(
        .WIDTH (DSIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (global_sys_clk),
        .rst_n      (rst_n),
        .wr_valid   (gen_valid),
        .wr_data    ({gen_last, gen_data}),
        .wr_ready_c (gen_ready),
        .rd_valid_c (chk_valid),
        .rd_data_c  ({chk_last, chk_data}),
        .rd_ready   (chk_ready)
    );

`ifdef TEST_TOP_BP_EN
    logic [1:0] bp_cnt;

    always_ff @(posedge global_sys_clk or negedge rst_n) begin
        if (!rst_n) bp_cnt <= '0;
        else        bp_cnt <= bp_cnt + 2'd1;
    end
    assign chk_ready = busy && (bp_cnt != 2'd3);
`else
    assign chk_ready = busy;
`endif

    assign chk_fire = chk_valid && chk_ready;
    assign beat_err = (chk_data != exp_d) || (chk_last != (exp_k == KW'(PKT_LEN - 1)));

    // Checker: expected pattern always advances so one bad beat costs one error.
    always_ff @(posedge global_sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            beat_cnt <= '0;
            exp_d    <= '0;
            exp_k    <= '0;
            all_seen <= 1'b0;
        end else if (run_start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            beat_cnt <= '0;
            exp_d    <= '0;
            exp_k    <= '0;
            all_seen <= 1'b0;
        end else begin
            if (chk_fire) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                exp_d    <= exp_d + DSIZE'(1);
                exp_k    <= (exp_k == KW'(PKT_LEN - 1)) ? '0 : exp_k + KW'(1);
                if (beat_err && (err_cnt != ERR_CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
                if (beat_cnt == CNT_W'(TOTAL - 1)) all_seen <= 1'b1;
            end
            if (all_seen) begin
                done     <= 1'b1;
                pass     <= (err_cnt == '0);
                busy     <= 1'b0;
                all_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_test_top_sys.sv
// Directed bench for test_top_sys with a run-timeline reference model and a beat monitor.
module tb_test_top_sys;

    localparam int TOTAL   = 64;
    localparam int PKT_LEN = 16;
    localparam int DONE_AT = TOTAL + 3;
    localparam int BP_MAX  = (4 * TOTAL) / 3 + 16 + 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        err_inject;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_cnt;
    logic [15:0] beat_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;
    int t0       = 0;
    int run_id   = 0;
    int inj_idx  = -1;
    int mon_run  = 0;
    int mon_idx  = 0;
    bit full_seen = 1'b0;

    test_top_sys dut (
        .global_sys_clk   (clk),
        .global_sys_rst_n (rst_n),
        .start            (start),
        .err_inject       (err_inject),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_cnt          (err_cnt),
        .beat_cnt         (beat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a run is a timeline in cycles since the start-registration edge.
    int m_t = -1;
    bit m_prev = 1'b0;
    bit m_pend = 1'b0;
    bit m_bb;
    int m_inj[$];

    function automatic bit m_busy();
        return (m_t >= 1) && (m_t < DONE_AT);
    endfunction
    function automatic int m_beats();
        if (m_t < 2) return 0;
        return (m_t - 2 > TOTAL) ? TOTAL : m_t - 2;
    endfunction
    function automatic int m_errs();
        int n = 0;
        foreach (m_inj[i]) if (m_t >= m_inj[i]) n++;
        return n;
    endfunction
    function automatic bit m_done();
        return m_t >= DONE_AT;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = -1; m_prev = 1'b0; m_pend = 1'b0;
            m_inj.delete();
        end else begin
            m_bb = m_busy();
            if (m_t >= 0) m_t++;
            if (m_pend && !m_bb) begin
                m_t = 1;
                m_inj.delete();
            end
            // Beat i is accepted at run edge i+2 and consumed at i+3.
            if (err_inject && m_t >= 2 && m_t <= TOTAL + 1) m_inj.push_back(m_t + 1);
            m_pend = start && !m_prev;
            m_prev = start;
        end
    end

`ifndef TEST_TOP_BP_EN
    always @(negedge clk) begin
        chk("busy", busy, m_busy());
        chk("done", done, m_done());
        chk("pass", pass, m_done() && (m_errs() == 0));
        chk("err_cnt", err_cnt, m_errs());
        chk("beat_cnt", beat_cnt, m_beats());
    end
`else
    always @(negedge clk) if (dut.u_fifo.full) full_seen = 1'b1;
`endif

    // Beat monitor at the checker input: counter pattern in order.
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (mon_run != run_id) begin
            mon_run = run_id;
            mon_idx = 0;
        end
        if (rst_n && dut.chk_valid && dut.chk_ready) begin
            mon_exp = 8'(mon_idx);
            if (mon_idx == inj_idx) mon_exp = mon_exp ^ 8'h01;
            chk("chk_tdata", dut.chk_data, mon_exp);
            chk("chk_tlast", dut.chk_last, (mon_idx % PKT_LEN) == PKT_LEN - 1);
            mon_idx++;
        end
    end

    task automatic kick(input bit new_run);
        @(negedge clk);
        start = 1'b1;
        if (new_run) run_id++;
        @(negedge clk);
        start = 1'b0;
        if (new_run) t0 = cyc_cnt;
    endtask

    task automatic wait_done(input string name);
        int lat;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) break;
        end
        lat = cyc_cnt - t0;
        chk({name, "_done"}, done, 1);
`ifndef TEST_TOP_BP_EN
        chk({name, "_latency"}, lat, DONE_AT);
`else
        chk({name, "_latency_bound"}, lat <= BP_MAX, 1);
`endif
    endtask

    task automatic wait_beats(input int n);
        bit hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (beat_cnt == 16'(n)) hit = 1'b1;
        end
        chk("wait_beats", hit, 1);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_pass"}, pass, 0);
        chk({name, "_err_cnt"}, err_cnt, 0);
        chk({name, "_beat_cnt"}, beat_cnt, 0);
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; err_inject = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Clean run at defaults.
        kick(1'b1);
        wait_done("clean");
        chk("clean_pass", pass, 1);
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_beat_cnt", beat_cnt, 64);

        // Corrupt packet 1 beat 3 (8'h13 sent as 8'h12).
        inj_idx = 19;
        kick(1'b1);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (dut.gen_valid && dut.gen_ready && dut.gen_data == 8'h13) found = 1'b1;
        end
        chk("inject_beat_found", found, 1);
        if (found) begin
            err_inject = 1'b1;
            @(negedge clk);
            err_inject = 1'b0;
        end
        wait_done("inject");
        chk("inject_err_cnt", err_cnt, 1);
        chk("inject_pass", pass, 0);
        chk("inject_beat_cnt", beat_cnt, 64);

        // Rerun clears counters.
        inj_idx = -1;
        kick(1'b1);
        @(negedge clk);
        chk("rerun_clr_err", err_cnt, 0);
        chk("rerun_clr_done", done, 0);
        chk("rerun_clr_beat", beat_cnt, 0);
        chk("rerun_busy", busy, 1);
        wait_done("rerun");
        chk("rerun_pass", pass, 1);
        chk("rerun_err_cnt", err_cnt, 0);

        // Start while busy is ignored.
        kick(1'b1);
        wait_beats(20);
        kick(1'b0);
        wait_done("busy_start");
        chk("busy_start_beat_cnt", beat_cnt, 64);
        chk("busy_start_pass", pass, 1);

        // Reset mid-run, then a clean run.
        kick(1'b1);
        wait_beats(30);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_zero("post_reset");
        kick(1'b1);
        wait_done("after_reset");
        chk("after_reset_pass", pass, 1);
        chk("after_reset_beat_cnt", beat_cnt, 64);
        chk("after_reset_err_cnt", err_cnt, 0);

`ifdef TEST_TOP_BP_EN
        chk("fifo_full_seen", full_seen, 1);
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/test_top_sys.md
Name: test_top_sys

Overview:
- Self-checking integration top used as the system-level smoke design.
- A packet generator pushes an AXI-Stream counter pattern through an internal synchronous FIFO into a checker.
- The checker compares every beat against the expected pattern and reports done/pass plus counters.
- Clocked by the board-level global system clock, with no external data interface.

Parameters:
- DSIZE, 8, tdata width in bits.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥4.
- PKT_LEN, 16, beats per packet; ≥2.
- PKT_NUM, 4, packets per run; ≥1.

Ports:
- global_sys_clk  input  1  system clock; all logic rising-edge.
- global_sys_rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; rising edge sampled.
- err_inject  input  1  corrupt the generator beat accepted in this cycle.
- busy  output  1  run in progress.
- done  output  1  run complete; sticky until next start or reset.
- pass  output  1  done && err_cnt==0.
- err_cnt  output  16  mismatching beats; saturates at 16'hFFFF.
- beat_cnt  output  16  beats consumed by the checker.

Behaviour:
- Reset: async assert, sync release. All outputs 0; FIFO empty; generator in IDLE.
- Start edge: start is registered; a 0→1 edge is detected.
  - Edge while busy=0: clears done, pass, err_cnt and beat_cnt, and moves the generator to SEND.
  - Edge while busy=1: ignored.
- Generator FSM: IDLE→SEND on the start edge; SEND→FINISH on the accepted beat that is the last beat of the last packet; FINISH→IDLE when the checker asserts done.
- busy=1 from the cycle after the start edge until done rises.
- Generator data: beat k (0..PKT_LEN-1) of packet p (0..PKT_NUM-1) carries tdata=(p*PKT_LEN+k) mod 2^DSIZE. tlast=1 when k==PKT_LEN-1.
- err_inject=1 on an accepted beat inverts tdata[0] of that beat only.
- Handshake: a beat transfers when valid&&ready.
  - The generator holds tdata/tlast stable while valid&&!ready.
  - Generator valid stays high throughout SEND.
- FIFO:
  - Stores {tlast,tdata}; write when in_valid&&!full; read when out_valid&&out_ready.
  - A written word appears at the output 1 cycle later (not fall-through).
  - Simultaneous read and write when full is allowed and leaves occupancy unchanged.
  - Simultaneous read and write when empty writes only.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full/empty are derived from the pointer MSB comparison.
- Checker:
  - ready=1 whenever busy (unless the optional feature masks it).
  - Keeps its own expected counter and increments beat_cnt on each consumed beat.
  - A beat whose tdata or tlast differs from expected increments err_cnt, saturating.
  - The expected counter always advances, so one corrupted beat costs exactly 1 error.
  - After consuming PKT_NUM*PKT_LEN beats: done=1 next cycle, pass=(err_cnt==0) in the same cycle.
- Timing without backpressure: 1 beat/cycle. done rises exactly PKT_NUM*PKT_LEN+3 cycles after the cycle the start edge is registered (67 at defaults).
- Reset mid-run: aborts immediately, flushes the FIFO, zeroes all counters.

Optional Feature:
- Macro TEST_TOP_BP_EN.
- Defined:
  - A free-running 2-bit counter deasserts checker ready whenever it equals 3, throttling the checker to 3 of every 4 cycles.
  - The FIFO fills and generator stalls occur; data must remain lossless.
  - pass behaviour is unchanged; done rises within 4*PKT_NUM*PKT_LEN/3+FIFO_DEPTH+4 cycles.
- Undefined: checker ready=busy; the counter is not built.

Decomposition:
- Package test_top_sys_pkg:
  - generator state enum (IDLE, SEND, FINISH);
  - TOTAL_BEATS=PKT_NUM*PKT_LEN localparam helper function;
  - err_cnt saturation max constant.
- One natural sub-module: axis_sync_fifo, parameterised by DSIZE+1 width and FIFO_DEPTH.
- Generator and checker stay inline in test_top_sys.

Test Plan:
- Reset release then start pulse, defaults → done=1 at start+67 cycles; pass=1, err_cnt=0, beat_cnt=64.
- err_inject high for one accepted beat (packet 1, beat 3, tdata 8'h13 sent as 8'h12) → err_cnt=1, pass=0, done=1, beat_cnt=64.
- Second start pulse after done → counters clear; clean rerun gives pass=1, err_cnt=0.
- Start pulse while busy at beat 20 → ignored; run completes with beat_cnt=64, pass=1.
- Reset asserted at beat 30, released, new start → all outputs 0 during reset; clean run gives pass=1, beat_cnt=64.
- With TEST_TOP_BP_EN → FIFO reaches full at least once; pass=1, beat_cnt=64; tdata sequence 0..63 consumed in order.
